// File: rtl/color_xform_sched_if.sv
// color_xform_sched_if: bus bundle between the scheduler, its two show-ahead
// source FIFOs, the colour transform and the downstream write FIFO.
//   a_* / b_*   : source FIFO flags, pop strobes and show-ahead pixel data
//   xf_*        : issue pulse and latched pixel to the transform
//   xf_*_i      : transform completion level and result pixel
//   out_*       : downstream FIFO full flag, push strobe and tagged result
// master = scheduler side, slave = surrounding FIFOs/transform side.
interface color_xform_sched_if;
    logic        a_empty;
    logic        a_rdreq;
    logic [9:0]  a_x;
    logic [9:0]  a_y;
    logic [23:0] a_rgb;
    logic        b_empty;
    logic        b_rdreq;
    logic [9:0]  b_x;
    logic [9:0]  b_y;
    logic [23:0] b_rgb;
    logic        xf_valid;
    logic [9:0]  xf_x;
    logic [9:0]  xf_y;
    logic [23:0] xf_rgb;
    logic        xf_wrreq;
    logic [9:0]  xf_x_i;
    logic [9:0]  xf_y_i;
    logic [23:0] xf_rgb_i;
    logic        out_full;
    logic        out_wrreq;
    logic        out_src;
    logic [9:0]  out_x;
    logic [9:0]  out_y;
    logic [23:0] out_rgb;

    modport master (
        input  a_empty, a_x, a_y, a_rgb, b_empty, b_x, b_y, b_rgb,
               xf_wrreq, xf_x_i, xf_y_i, xf_rgb_i, out_full,
        output a_rdreq, b_rdreq, xf_valid, xf_x, xf_y, xf_rgb,
               out_wrreq, out_src, out_x, out_y, out_rgb
    );

    modport slave (
        output a_empty, a_x, a_y, a_rgb, b_empty, b_x, b_y, b_rgb,
               xf_wrreq, xf_x_i, xf_y_i, xf_rgb_i, out_full,
        input  a_rdreq, b_rdreq, xf_valid, xf_x, xf_y, xf_rgb,
               out_wrreq, out_src, out_x, out_y, out_rgb
    );
endinterface

// File: rtl/color_xform_sched.sv
// color_xform_sched: round-robin scheduler sharing one colour transform
// between pixel sources A and B, one pixel in flight at a time.
//   clk_25      : system clock, rising edge
//   reset       : asynchronous active-low reset
//   enable      : gates new grants only
//   bus         : source, transform and output FIFO signals (master side)
//   busy        : high whenever not IDLE
//   timeout_err : sticky, set when the transform never completes
//   cnt_a/cnt_b : wrapping count of results pushed per source
module color_xform_sched #(
    parameter logic [7:0] TIMEOUT = 8'd16
) (
    input  logic                       clk_25,
    input  logic                       reset,
    input  logic                       enable,
    color_xform_sched_if.master        bus,
    output logic                       busy,
    output logic                       timeout_err,
    output logic [15:0]                cnt_a,
    output logic [15:0]                cnt_b
);
    typedef enum logic [1:0] {IDLE, ISSUE, BUSY, OUT} state_t;

    state_t      state;
    state_t      state_nx;
    logic        last_b;
    logic        owner;
    logic        xf_wrreq_d;
    logic [7:0]  tmo_cnt;
    logic        cand_a;
    logic        cand_b;
    logic        grant_a;
    logic        grant_b;
    logic        done_edge;
    logic        tmo_hit;

    // reset gates the candidates so the pop strobes read 0 while reset is held
    assign cand_a    = reset && enable && state == IDLE && !bus.a_empty;
    assign cand_b    = reset && enable && state == IDLE && !bus.b_empty;
    assign grant_a   = cand_a && (!cand_b || last_b);
    assign grant_b   = cand_b && (!cand_a || !last_b);
    assign done_edge = bus.xf_wrreq && !xf_wrreq_d;
    assign tmo_hit   = tmo_cnt == TIMEOUT - 8'd1;

    always_comb begin
        state_nx      = state;
        bus.a_rdreq   = grant_a;
        bus.b_rdreq   = grant_b;
        bus.xf_valid  = state == ISSUE;
        bus.out_wrreq = state == OUT && !bus.out_full;
        busy          = state != IDLE;
        case (state)
            IDLE:    state_nx = (grant_a || grant_b) ? ISSUE : IDLE;
            ISSUE:   state_nx = BUSY;
            BUSY:    state_nx = done_edge ? OUT : (tmo_hit ? IDLE : BUSY);
            default: state_nx = bus.out_full ? OUT : IDLE;
        endcase
    end

    always_ff @(posedge clk_25 or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            last_b      <= 1'b1;
            owner       <= 1'b0;
            xf_wrreq_d  <= 1'b0;
            tmo_cnt     <= 8'd0;
            timeout_err <= 1'b0;
            cnt_a       <= 16'd0;
            cnt_b       <= 16'd0;
            bus.xf_x    <= 10'd0;
            bus.xf_y    <= 10'd0;
            bus.xf_rgb  <= 24'd0;
            bus.out_src <= 1'b0;
            bus.out_x   <= 10'd0;
            bus.out_y   <= 10'd0;
            bus.out_rgb <= 24'd0;
        end else begin
            state      <= state_nx;
            xf_wrreq_d <= bus.xf_wrreq;
            if (grant_a || grant_b) begin
                bus.xf_x   <= grant_b ? bus.b_x : bus.a_x;
                bus.xf_y   <= grant_b ? bus.b_y : bus.a_y;
                bus.xf_rgb <= grant_b ? bus.b_rgb : bus.a_rgb;
                owner      <= grant_b;
                last_b     <= grant_b;
            end
            if (state == ISSUE)
                tmo_cnt <= 8'd0;
            // a completion edge takes priority over a timeout in the same cycle
            if (state == BUSY && done_edge) begin
                bus.out_x   <= bus.xf_x_i;
                bus.out_y   <= bus.xf_y_i;
                bus.out_rgb <= bus.xf_rgb_i;
                bus.out_src <= owner;
            end
            if (state == BUSY && !done_edge) begin
                tmo_cnt <= tmo_cnt + 8'd1;
                if (tmo_hit)
                    timeout_err <= 1'b1;
            end
            if (bus.out_wrreq && !owner)
                cnt_a <= cnt_a + 16'd1;
            if (bus.out_wrreq && owner)
                cnt_b <= cnt_b + 16'd1;
        end
    end
endmodule
